period_meter: RTL and testbench
===============================

PERIOD_METER -- requirements
Module: period_meter

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, giving the width of the measurement counters and outputs; legal range 4..32.
REQ-002 The block SHALL have port clock, input, 1 bit: the single measurement clock, rising-edge active.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset (asserted when 0).
REQ-004 The block SHALL have port enable, input, 1 bit: measurement is permitted while 1.
REQ-005 The block SHALL have port div_in, input, 1 bit: the slow divided clock under measurement, asynchronous to clock.
REQ-006 The block SHALL have port period, output, CNT_W bits: the last full period of div_in, in clock cycles.
REQ-007 The block SHALL have port high_time, output, CNT_W bits: the last high phase of div_in, in clock cycles.
REQ-008 The block SHALL have port valid, output, 1 bit: a one-cycle pulse when period is updated.
REQ-009 The block SHALL have port locked, output, 1 bit: high while the two most recent periods are equal.
REQ-010 The block SHALL have port timeout, output, 1 bit: high when no rising edge is seen within 2^CNT_W-1 cycles.

Function
REQ-011 div_in SHALL pass through a 2-flop synchronizer (s1, s2) and a history flop (s3); define rise = s2 & ~s3 and fall = ~s2 & s3.
REQ-012 A div_in transition sampled at clock edge k SHALL produce rise or fall during the cycle after edge k+1, so detection latency is 2 clocks.
REQ-013 The FSM SHALL have states IDLE, ARM, MEASURE and TIMEOUT.
REQ-014 In IDLE with enable=1 the FSM SHALL go to ARM; in any state, enable=0 SHALL force IDLE on the next edge.
REQ-015 In ARM, a rise SHALL load cnt<=1 and high_cnt<=1, go to MEASURE and SHALL NOT assert valid.
REQ-016 In MEASURE, on each edge without rise, cnt SHALL increment by 1.
REQ-017 In MEASURE, on an edge with rise: period<=cnt, cnt<=1, high_cnt<=1, and valid=1 for exactly the next cycle.
REQ-018 The result of REQ-017 SHALL be that rises N edges apart give period=N.
REQ-019 high_cnt SHALL increment on each edge while s2=1 with no rise.
REQ-020 On a fall in MEASURE, high_time SHALL load high_cnt, so a high phase of H cycles gives high_time=H.
REQ-021 high_time SHALL NOT change valid.
REQ-022 locked SHALL be set on a valid update whose new period equals the previous period.
REQ-023 locked SHALL be cleared on a valid update with a mismatch, and on entry to TIMEOUT or IDLE.
REQ-024 The first valid update after ARM SHALL NOT set locked; it needs a prior period.
REQ-025 In MEASURE, if cnt=2^CNT_W-1 and there is no rise, the FSM SHALL enter TIMEOUT and set timeout=1, and cnt SHALL saturate (never wrap).
REQ-026 If rise and cnt=2^CNT_W-1 occur together, the rise SHALL take priority: normal update per REQ-017, no timeout.
REQ-027 In TIMEOUT, a rise SHALL clear timeout and restart as from ARM (cnt<=1, MEASURE, no valid).
REQ-028 timeout SHALL also clear on enable=0.
REQ-029 period and high_time SHALL hold their last values across IDLE and TIMEOUT, and SHALL change only per REQ-017 and REQ-020.
REQ-030 high_cnt SHALL saturate at 2^CNT_W-1.

Reset
REQ-031 While reset=0, all flops SHALL clear asynchronously: state=IDLE, s1/s2/s3=0, cnt=0, high_cnt=0, period=0, high_time=0, valid=0, locked=0, timeout=0.
REQ-032 Release of reset SHALL take effect on the first clock edge with reset=1.
REQ-033 Reset asserted mid-measurement SHALL discard the partial count, with no valid pulse.

Verification
REQ-034 CNT_W=16, enable=1, div_in toggling every 17 clocks (period 34) -> first valid carries period=34 and high_time=17 with locked=0; second valid gives locked=1.
REQ-035 Period changed from 34 to 36 mid-stream -> the valid with period=36 drops locked to 0; the following valid with period=36 sets locked to 1.
REQ-036 CNT_W=4, div_in held low after one rise -> timeout=1 after 15 cycles, locked=0, period unchanged; the next rise clears timeout with no valid.
REQ-037 CNT_W=4, rise exactly when cnt=15 -> valid with period=15, timeout stays 0.
REQ-038 reset pulsed low for 1 cycle mid-period -> all outputs 0 immediately; the first rise after release produces no valid.
REQ-039 enable dropped for 5 cycles while locked -> locked=0, period/high_time held, no valid until two further rises.

Source files
------------

// File: rtl/period_meter.sv
// Measures period and high phase of a slow, asynchronous divided clock in clock cycles,
// and flags lock (two equal consecutive periods) and loss of edges (timeout).
//
// state      | meaning
// -----------+--------------------------------------------------------------
// ST_IDLE    | measurement disabled; lock/timeout cleared, results held
// ST_ARM     | enabled, waiting for the first rising edge to start counting
// ST_MEASURE | counting between rising edges; each rise publishes a period
// ST_TIMEOUT | no rising edge within 2^CNT_W-1 cycles; next rise restarts
module period_meter #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             div_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             locked,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] C_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] C_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_MEASURE,
        ST_TIMEOUT
    } state_t;

    state_t           r_state;
    logic             r_s1;
    logic             r_s2;
    logic             r_s3;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_high_cnt;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_high_time;
    logic             r_valid;
    logic             r_locked;
    logic             r_timeout;
    logic             r_have_prev;

    logic w_rise;
    logic w_fall;
    logic w_cnt_max;
    logic w_high_max;

    assign w_rise     = r_s2 & ~r_s3;
    assign w_fall     = ~r_s2 & r_s3;
    assign w_cnt_max  = (r_cnt == C_MAX);
    assign w_high_max = (r_high_cnt == C_MAX);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= div_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_high_cnt  <= '0;
            r_period    <= '0;
            r_high_time <= '0;
            r_valid     <= 1'b0;
            r_locked    <= 1'b0;
            r_timeout   <= 1'b0;
            r_have_prev <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (!enable) begin
                r_state     <= ST_IDLE;
                r_locked    <= 1'b0;
                r_timeout   <= 1'b0;
                r_have_prev <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state <= ST_ARM;
                    end
                    ST_ARM: begin
                        if (w_rise) begin
                            r_cnt       <= C_ONE;
                            r_high_cnt  <= C_ONE;
                            r_have_prev <= 1'b0;
                            r_state     <= ST_MEASURE;
                        end
                    end
                    ST_MEASURE: begin
                        if (w_rise) begin
                            // Lock compares against the period being replaced, so the
                            // first update after arming can never lock.
                            r_period    <= r_cnt;
                            r_locked    <= r_have_prev && (r_cnt == r_period);
                            r_have_prev <= 1'b1;
                            r_cnt       <= C_ONE;
                            r_high_cnt  <= C_ONE;
                            r_valid     <= 1'b1;
                        end else begin
                            if (w_cnt_max) begin
                                r_state   <= ST_TIMEOUT;
                                r_timeout <= 1'b1;
                                r_locked  <= 1'b0;
                            end else begin
                                r_cnt <= r_cnt + C_ONE;
                            end
                            if (r_s2 && !w_high_max) begin
                                r_high_cnt <= r_high_cnt + C_ONE;
                            end
                            if (w_fall) begin
                                r_high_time <= r_high_cnt;
                            end
                        end
                    end
                    ST_TIMEOUT: begin
                        if (w_rise) begin
                            r_timeout   <= 1'b0;
                            r_cnt       <= C_ONE;
                            r_high_cnt  <= C_ONE;
                            r_have_prev <= 1'b0;
                            r_state     <= ST_MEASURE;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign period    = r_period;
    assign high_time = r_high_time;
    assign valid     = r_valid;
    assign locked    = r_locked;
    assign timeout   = r_timeout;

endmodule

// File: tb/tb_period_meter.sv
// Bench for period_meter: a 16-bit instance runs the table-driven period sequences,
// a 4-bit instance covers the timeout boundary; valid pulses are checked against a queue.
module tb_period_meter;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        rst16_n, en16, div16;
    logic [15:0] period16, high16;
    logic        valid16, locked16, to16;

    logic        rst4_n, en4, div4;
    logic [3:0]  period4, high4;
    logic        valid4, locked4, to4;

    period_meter #(.CNT_W(16)) dut16 (
        .clock(clock), .reset(rst16_n), .enable(en16), .div_in(div16),
        .period(period16), .high_time(high16), .valid(valid16),
        .locked(locked16), .timeout(to16)
    );

    period_meter #(.CNT_W(4)) dut4 (
        .clock(clock), .reset(rst4_n), .enable(en4), .div_in(div4),
        .period(period4), .high_time(high4), .valid(valid4),
        .locked(locked4), .timeout(to4)
    );

    typedef struct {
        logic [31:0] p;
        logic [31:0] h;
        logic        l;
    } exp_t;

    typedef struct {
        int hi;
        int lo;
        bit push;
        int ep;
        int eh;
        bit el;
    } vec_t;

    exp_t q16[$];
    exp_t q4[$];
    exp_t em16;
    exp_t em4;
    vec_t tbl[11];
    int   n_checks = 0;
    int   n_fails  = 0;
    bit   to4_seen = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One div_in cycle: rise now, fall after hi cycles, next rise after hi+lo cycles.
    // The expectation pushed belongs to the valid this rise produces (previous period).
    task automatic pulse(input bit sel4, input int hi, input int lo,
                         input bit push, input int ep, input int eh, input bit el);
        exp_t e;
        e.p = ep;
        e.h = eh;
        e.l = el;
        if (sel4) begin
            div4 = 1'b1;
            if (push) q4.push_back(e);
        end else begin
            div16 = 1'b1;
            if (push) q16.push_back(e);
        end
        repeat (hi) @(negedge clock);
        if (sel4) div4 = 1'b0;
        else div16 = 1'b0;
        repeat (lo) @(negedge clock);
    endtask

    initial begin
        rst16_n = 1'b0; en16 = 1'b0; div16 = 1'b0;
        rst4_n  = 1'b0; en4  = 1'b0; div4  = 1'b0;

        fork
            forever begin
                @(negedge clock);
                if (to4) to4_seen = 1'b1;
                if (valid16) begin
                    check("valid16 has expectation", 32'(q16.size() != 0), 1);
                    if (q16.size() != 0) begin
                        em16 = q16.pop_front();
                        check("period16", 32'(period16), em16.p);
                        check("high_time16", 32'(high16), em16.h);
                        check("locked16", 32'(locked16), 32'(em16.l));
                    end
                end
                if (valid4) begin
                    check("valid4 has expectation", 32'(q4.size() != 0), 1);
                    if (q4.size() != 0) begin
                        em4 = q4.pop_front();
                        check("period4", 32'(period4), em4.p);
                        check("high_time4", 32'(high4), em4.h);
                        check("locked4", 32'(locked4), 32'(em4.l));
                    end
                end
            end
            begin
                #500000;
                $display("FAIL watchdog: simulation time limit reached");
                $fatal(1, "watchdog");
            end
        join_none

        repeat (3) @(negedge clock);
        check("reset period16", 32'(period16), 0);
        check("reset high_time16", 32'(high16), 0);
        check("reset valid16", 32'(valid16), 0);
        check("reset locked16", 32'(locked16), 0);
        check("reset timeout16", 32'(to16), 0);
        check("reset period4", 32'(period4), 0);
        check("reset timeout4", 32'(to4), 0);

        rst16_n = 1'b1;
        rst4_n  = 1'b1;
        en16    = 1'b1;
        @(negedge clock);

        // hi, lo, push, expected period/high_time/locked of the valid at this row's rise
        tbl = '{
            '{17, 17, 1'b0,  0,  0, 1'b0},
            '{17, 17, 1'b1, 34, 17, 1'b0},
            '{17, 17, 1'b1, 34, 17, 1'b1},
            '{18, 18, 1'b1, 34, 17, 1'b1},
            '{18, 18, 1'b1, 36, 18, 1'b0},
            '{10, 26, 1'b1, 36, 18, 1'b1},
            '{ 5, 31, 1'b1, 36, 10, 1'b1},
            '{20, 20, 1'b1, 36,  5, 1'b1},
            '{ 3,  3, 1'b1, 40, 20, 1'b0},
            '{ 3,  3, 1'b1,  6,  3, 1'b0},
            '{17, 17, 1'b1,  6,  3, 1'b1}
        };
        for (int i = 0; i < 11; i++) begin
            pulse(1'b0, tbl[i].hi, tbl[i].lo, tbl[i].push, tbl[i].ep, tbl[i].eh, tbl[i].el);
        end
        check("timeout16 after table", 32'(to16), 0);
        check("locked16 after table", 32'(locked16), 1);

        // enable dropped while locked
        en16 = 1'b0;
        repeat (5) @(negedge clock);
        check("locked16 while disabled", 32'(locked16), 0);
        check("period16 held while disabled", 32'(period16), 6);
        check("high_time16 held while disabled", 32'(high16), 17);
        en16 = 1'b1;
        @(negedge clock);
        pulse(1'b0, 12, 12, 1'b0, 0, 0, 1'b0);
        pulse(1'b0, 12, 12, 1'b1, 24, 12, 1'b0);
        pulse(1'b0, 12, 12, 1'b1, 24, 12, 1'b1);

        // one-cycle reset mid-period
        rst16_n = 1'b0;
        #1;
        check("mid reset period16", 32'(period16), 0);
        check("mid reset high_time16", 32'(high16), 0);
        check("mid reset valid16", 32'(valid16), 0);
        check("mid reset locked16", 32'(locked16), 0);
        check("mid reset timeout16", 32'(to16), 0);
        @(negedge clock);
        rst16_n = 1'b1;
        pulse(1'b0, 8, 8, 1'b0, 0, 0, 1'b0);
        pulse(1'b0, 8, 8, 1'b1, 16, 8, 1'b0);
        pulse(1'b0, 8, 8, 1'b1, 16, 8, 1'b1);
        check("queue16 drained", 32'(q16.size()), 0);

        // CNT_W=4: rise exactly at cnt=15 wins over timeout
        en4 = 1'b1;
        @(negedge clock);
        to4_seen = 1'b0;
        pulse(1'b1, 5, 10, 1'b0, 0, 0, 1'b0);
        pulse(1'b1, 5, 10, 1'b1, 15, 5, 1'b0);
        em4.p = 15; em4.h = 5; em4.l = 1'b1;
        div4 = 1'b1;
        q4.push_back(em4);
        repeat (5) @(negedge clock);
        div4 = 1'b0;
        repeat (12) @(negedge clock);
        check("timeout4 never set with rise at cnt=15", 32'(to4_seen), 0);
        check("timeout4 one cycle before limit", 32'(to4), 0);
        @(negedge clock);
        check("timeout4 at limit", 32'(to4), 1);
        check("locked4 cleared by timeout", 32'(locked4), 0);
        check("period4 held in timeout", 32'(period4), 15);
        check("high_time4 held in timeout", 32'(high4), 5);

        // rise in timeout restarts without a valid
        div4 = 1'b1;
        repeat (3) @(negedge clock);
        check("timeout4 cleared by rise", 32'(to4), 0);
        repeat (2) @(negedge clock);
        div4 = 1'b0;
        repeat (5) @(negedge clock);
        pulse(1'b1, 5, 5, 1'b1, 10, 5, 1'b0);
        repeat (20) @(negedge clock);
        check("timeout4 after second stall", 32'(to4), 1);
        en4 = 1'b0;
        @(negedge clock);
        check("timeout4 cleared by disable", 32'(to4), 0);
        check("queue4 drained", 32'(q4.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
